// File: rtl/seq_div_nbit_if.sv
// seq_div_nbit_if: start/busy/done handshake and operand/result bus of the sequential divider.
interface seq_div_nbit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   modport master (output start, is_signed, dividend, divisor,
                   input  busy, done, div_by_zero, quotient, remainder);
   modport slave  (input  start, is_signed, dividend, divisor,
                   output busy, done, div_by_zero, quotient, remainder);
endinterface

// File: rtl/seq_div_nbit.sv
// seq_div_nbit: multi-cycle restoring divider, UNROLL quotient bits per clock, signed or unsigned.
module seq_div_nbit #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input logic          clk,
   input logic          reset,
   seq_div_nbit_if.slave bus
);
   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t             state;
   logic [2*WIDTH-1:0] acc, acc_n;
   logic [2*WIDTH:0]   sh;
   logic [WIDTH-1:0]   diff, dvsr, mag_a, mag_b;
   logic [CW-1:0]      cnt;
   logic               sign_q, sign_r, ge;
   assign mag_a = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
   assign mag_b = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
   // sh keeps the bit shifted out of the upper half so the trial compare is WIDTH+1 bits wide
   always_comb begin
      acc_n = acc;
      sh    = '0;
      diff  = '0;
      ge    = 1'b0;
      for (int i = 0; i < UNROLL; i++) begin
         sh    = {acc_n, 1'b0};
         ge    = sh[2*WIDTH:WIDTH] >= {1'b0, dvsr};
         diff  = sh[2*WIDTH-1:WIDTH] - dvsr;
         acc_n = ge ? {diff, sh[WIDTH-1:1], 1'b1} : sh[2*WIDTH-1:0];
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         acc         <= '0;
         dvsr        <= '0;
         cnt         <= '0;
         sign_q      <= 1'b0;
         sign_r      <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.div_by_zero <= 1'b0;
         bus.quotient    <= '0;
         bus.remainder   <= '0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               sign_q          <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
               sign_r          <= bus.is_signed & bus.dividend[WIDTH-1];
               acc             <= {{WIDTH{1'b0}}, mag_a};
               dvsr            <= mag_b;
               cnt             <= CW'(N);
               bus.div_by_zero <= 1'b0;
               if (bus.divisor == '0) begin
                  bus.quotient    <= '1;
                  bus.remainder   <= bus.dividend;
                  bus.div_by_zero <= 1'b1;
                  bus.done        <= 1'b1;
                  state           <= DONE;
               end else begin
                  bus.busy <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               acc <= acc_n;
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= FIX;
            end
            FIX: begin
               bus.quotient  <= sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
               bus.remainder <= sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
               bus.busy      <= 1'b0;
               bus.done      <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_seq_div_nbit.sv
// tb_seq_div_nbit: directed and random checks of seq_div_nbit at 32/1 and 16/4 against an arithmetic model.
module tb_seq_div_nbit;
   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;
   always #5 clk = ~clk;
   seq_div_nbit_if #(.WIDTH(32)) b32 ();
   seq_div_nbit_if #(.WIDTH(16)) b16 ();
   seq_div_nbit #(.WIDTH(32), .UNROLL(1)) u32 (.clk(clk), .reset(reset), .bus(b32));
   seq_div_nbit #(.WIDTH(16), .UNROLL(4)) u16 (.clk(clk), .reset(reset), .bus(b16));
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drv(input bit w16, input logic st, input bit s, input logic [63:0] a, input logic [63:0] b);
      if (w16) begin
         b16.start = st; b16.is_signed = s; b16.dividend = a[15:0]; b16.divisor = b[15:0];
      end else begin
         b32.start = st; b32.is_signed = s; b32.dividend = a[31:0]; b32.divisor = b[31:0];
      end
   endtask
   // Issues one op; optionally re-asserts start with other operands in cycle inj while busy.
   task automatic run(input bit w16, input logic [63:0] a, input logic [63:0] b, input bit s, input int inj,
                      output logic [63:0] q, output logic [63:0] r, output bit dz, output int lat, output bit busy_ok);
      @(negedge clk);
      drv(w16, 1'b1, s, a, b);
      @(posedge clk); #1;
      lat = 1;
      busy_ok = 1'b1;
      while (!(w16 ? b16.done : b32.done) && lat < 100) begin
         if (!(w16 ? b16.busy : b32.busy)) busy_ok = 1'b0;
         drv(w16, lat == inj, 1'($urandom_range(0, 1)),
             lat == inj ? 64'd1000 : {$urandom, $urandom}, lat == inj ? 64'd3 : {$urandom, $urandom});
         @(posedge clk); #1;
         lat++;
      end
      drv(w16, 1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
      if (w16 ? b16.busy : b32.busy) busy_ok = 1'b0;
      q  = w16 ? 64'(b16.quotient)  : 64'(b32.quotient);
      r  = w16 ? 64'(b16.remainder) : 64'(b32.remainder);
      dz = w16 ? b16.div_by_zero : b32.div_by_zero;
      @(posedge clk); #1;
   endtask
   function automatic void model(input int w, input logic [63:0] a, input logic [63:0] b, input bit s,
                                 output logic [63:0] q, output logic [63:0] r, output bit dz);
      logic [63:0] m;
      longint      av, bv;
      m  = (64'd1 << w) - 64'd1;
      av = s ? ($signed((a & m) << (64 - w)) >>> (64 - w)) : $signed(a & m);
      bv = s ? ($signed((b & m) << (64 - w)) >>> (64 - w)) : $signed(b & m);
      dz = (b & m) == 64'd0;
      if (dz) begin
         q = m;
         r = a & m;
      end else begin
         q = 64'(av / bv) & m;
         r = 64'(av % bv) & m;
      end
   endfunction
   function automatic logic [63:0] pick(input int w);
      logic [63:0] m;
      m = (64'd1 << w) - 64'd1;
      case ($urandom_range(0, 7))
         0:       return 64'd0;
         1:       return m;
         2:       return 64'd1 << (w - 1);
         3:       return 64'd1;
         4:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom} & m;
      endcase
   endfunction
   initial begin
      logic [63:0] q, r, eq, er, a, b;
      bit          dz, edz, bok, s;
      int          lat, w;
      reset = 1'b0;
      drv(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      drv(1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
      #1;
      chk("rst_busy", 64'(b32.busy), 64'd0);
      chk("rst_done", 64'(b32.done), 64'd0);
      chk("rst_q", 64'(b32.quotient), 64'd0);
      chk("rst_r", 64'(b32.remainder), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      run(1'b0, 64'd100, 64'd7, 1'b0, 0, q, r, dz, lat, bok);
      chk("u100_7_q", q, 64'd14);
      chk("u100_7_r", r, 64'd2);
      chk("u100_7_lat", 64'(lat), 64'd34);
      chk("u100_7_busy", 64'(bok), 64'd1);
      chk("u100_7_dz", 64'(dz), 64'd0);
      run(1'b0, 64'hFFFFFFF9, 64'd2, 1'b1, 0, q, r, dz, lat, bok);
      chk("sm7_2_q", q, 64'hFFFFFFFD);
      chk("sm7_2_r", r, 64'hFFFFFFFF);
      run(1'b0, 64'd7, 64'hFFFFFFFE, 1'b1, 0, q, r, dz, lat, bok);
      chk("s7_m2_q", q, 64'hFFFFFFFD);
      chk("s7_m2_r", r, 64'd1);
      run(1'b0, 64'hFFFFFFF9, 64'd2, 1'b0, 0, q, r, dz, lat, bok);
      chk("ubig_2_q", q, 64'h7FFFFFFC);
      chk("ubig_2_r", r, 64'd1);
      run(1'b0, 64'd5, 64'd0, 1'b0, 0, q, r, dz, lat, bok);
      chk("dz_q", q, 64'hFFFFFFFF);
      chk("dz_r", r, 64'd5);
      chk("dz_flag", 64'(dz), 64'd1);
      chk("dz_lat", 64'(lat), 64'd1);
      run(1'b0, 64'd100, 64'd7, 1'b0, 0, q, r, dz, lat, bok);
      chk("dz_clear", 64'(dz), 64'd0);
      run(1'b0, 64'h80000000, 64'hFFFFFFFF, 1'b1, 0, q, r, dz, lat, bok);
      chk("ovf_q", q, 64'h80000000);
      chk("ovf_r", r, 64'd0);
      chk("ovf_dz", 64'(dz), 64'd0);
      run(1'b0, 64'd0, 64'd9, 1'b0, 0, q, r, dz, lat, bok);
      chk("zero_q", q, 64'd0);
      chk("zero_r", r, 64'd0);
      chk("zero_lat", 64'(lat), 64'd34);
      run(1'b0, 64'd100, 64'd7, 1'b0, 5, q, r, dz, lat, bok);
      chk("inj_q", q, 64'd14);
      chk("inj_r", r, 64'd2);
      chk("inj_lat", 64'(lat), 64'd34);
      repeat (3) @(posedge clk);
      #1;
      chk("inj_idle", 64'({b32.busy, b32.done}), 64'd0);
      @(negedge clk);
      drv(1'b0, 1'b1, 1'b0, 64'd1000, 64'd3);
      @(posedge clk); #1;
      drv(1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
      repeat (9) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_rst_busy", 64'(b32.busy), 64'd0);
      chk("mid_rst_done", 64'(b32.done), 64'd0);
      chk("mid_rst_dz", 64'(b32.div_by_zero), 64'd0);
      chk("mid_rst_q", 64'(b32.quotient), 64'd0);
      chk("mid_rst_r", 64'(b32.remainder), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_idle", 64'({b32.busy, b32.done}), 64'd0);
      run(1'b0, 64'd1000, 64'd3, 1'b0, 0, q, r, dz, lat, bok);
      chk("post_rst_q", q, 64'd333);
      chk("post_rst_r", r, 64'd1);
      chk("post_rst_lat", 64'(lat), 64'd34);
      run(1'b1, 64'hFFFF, 64'h0003, 1'b0, 0, q, r, dz, lat, bok);
      chk("u16_q", q, 64'h5555);
      chk("u16_r", r, 64'd0);
      chk("u16_lat", 64'(lat), 64'd6);
      chk("u16_busy", 64'(bok), 64'd1);
      for (int i = 0; i < 1200; i++) begin
         w = (i < 1000) ? 16 : 32;
         s = 1'($urandom_range(0, 1));
         a = pick(w);
         b = pick(w);
         model(w, a, b, s, eq, er, edz);
         run(w == 16, a, b, s, 0, q, r, dz, lat, bok);
         chk(w == 16 ? "rnd16_q" : "rnd32_q", q, eq);
         chk(w == 16 ? "rnd16_r" : "rnd32_r", r, er);
         chk(w == 16 ? "rnd16_dz" : "rnd32_dz", 64'(dz), 64'(edz));
         chk(w == 16 ? "rnd16_lat" : "rnd32_lat", 64'(lat), edz ? 64'd1 : (w == 16 ? 64'd6 : 64'd34));
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
